// File: rtl/dc_responder.sv
// dc_responder: fixed-latency load/store responder on the shader core dc_* bus.
// Owns a word-organised local data RAM with byte-enabled writes and a registered
// read port. One request is active at a time; a single pending entry absorbs a
// request that arrives while another is in flight, anything beyond is dropped.
// Optional macro: DC_RESP_MISALIGN_TRAP_EN -- misaligned half/word accesses return
// an error response and never write, instead of being silently aligned down.
module dc_responder #(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] dc_addr_i,
  input  logic [31:0] dc_data_i,
  input  logic [2:0]  dc_op_i,
  input  logic        dc_valid_i,
  output logic [31:0] dc_data_o,
  output logic        dc_valid_o,
  output logic        busy_o,
  output logic        ovf_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_state_next;
  logic [AW+1:0] r_act_addr, r_pend_addr;
  logic [31:0]   r_act_data, r_pend_data;
  logic [2:0]    r_act_op, r_pend_op;
  logic          r_pend_valid;
  logic          r_ovf;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_data_hold;
  logic [31:0]   r_rd_word;
  logic [31:0]   r_mem [DEPTH];

  logic          w_take_new, w_take_pend, w_to_pend, w_drop;
  logic          w_access, w_is_store, w_mis, w_we;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_result;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_unused;

  // Address bits above the RAM size alias onto the same words.
  assign w_unused = ^dc_addr_i[31:AW+2];

  assign w_is_store = (r_act_op == OP_SB) || (r_act_op == OP_SH) || (r_act_op == OP_SW);
  assign w_access   = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_we       = w_access && w_is_store && !w_mis;
  assign w_idx      = r_act_addr[AW+1:2];

`ifdef DC_RESP_MISALIGN_TRAP_EN
  // Flag half/word accesses whose address is not naturally aligned.
  always_comb begin
    w_mis = 1'b0;
    case (r_act_op)
      OP_LH, OP_LHU, OP_SH: w_mis = r_act_addr[0];
      OP_LW, OP_SW:         w_mis = (r_act_addr[1:0] != 2'b00);
      default:              w_mis = 1'b0;
    endcase
  end
  assign err_o = (r_state == S_RESP) && w_mis;
`else
  assign w_mis = 1'b0;
  assign err_o = 1'b0;
`endif

  // Byte lanes: SB/SH replicate the low byte/half so the enables pick the lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_be[gi] = (r_act_op == OP_SB) ? (r_act_addr[1:0] == 2'(gi)) :
                      (r_act_op == OP_SH) ? (r_act_addr[1] == 1'(gi / 2)) : 1'b1;
    assign w_wdata[8*gi +: 8] = (r_act_op == OP_SB) ? r_act_data[7:0] :
                                (r_act_op == OP_SH) ? r_act_data[8*(gi % 2) +: 8] :
                                                      r_act_data[8*gi +: 8];
  end

  assign w_byte = r_rd_word[{r_act_addr[1:0], 3'b000} +: 8];
  assign w_half = r_act_addr[1] ? r_rd_word[31:16] : r_rd_word[15:0];

  // Load lane select and extension from the registered RAM word; stores/errors give 0.
  always_comb begin
    w_result = 32'h0;
    if (!w_is_store && !w_mis) begin
      case (r_act_op)
        OP_LB:   w_result = {{24{w_byte[7]}}, w_byte};
        OP_LH:   w_result = {{16{w_half[15]}}, w_half};
        OP_LW:   w_result = r_rd_word;
        OP_LBU:  w_result = {24'h0, w_byte};
        OP_LHU:  w_result = {16'h0, w_half};
        default: w_result = 32'h0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next state and steering of incoming requests (activate, park in pending, drop).
  // A request arriving in RESP with pending empty is dispatched straight into WAIT;
  // that is the same timing it would get by passing through the pending entry.
  always_comb begin
    w_state_next = r_state;
    w_take_new   = 1'b0;
    w_take_pend  = 1'b0;
    w_to_pend    = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dc_valid_i) begin
          w_take_new   = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_next = S_RESP;
        if (dc_valid_i) begin
          if (r_pend_valid) w_drop    = 1'b1;
          else              w_to_pend = 1'b1;
        end
      end
      S_RESP: begin
        if (r_pend_valid) begin
          w_take_pend  = 1'b1;
          w_drop       = dc_valid_i;
          w_state_next = S_WAIT;
        end else if (dc_valid_i) begin
          w_take_new   = 1'b1;
          w_state_next = S_WAIT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Active/pending request registers, latency counter, sticky overflow, output hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_act_addr   <= '0;
      r_act_data   <= '0;
      r_act_op     <= '0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_pend_op    <= '0;
      r_pend_valid <= 1'b0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_data_hold  <= '0;
    end else begin
      if (w_take_new) begin
        r_act_addr <= dc_addr_i[AW+1:0];
        r_act_data <= dc_data_i;
        r_act_op   <= dc_op_i;
        r_cnt      <= CNT_INIT;
      end else if (w_take_pend) begin
        r_act_addr <= r_pend_addr;
        r_act_data <= r_pend_data;
        r_act_op   <= r_pend_op;
        r_cnt      <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_to_pend) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= dc_addr_i[AW+1:0];
        r_pend_data  <= dc_data_i;
        r_pend_op    <= dc_op_i;
      end else if (w_take_pend) begin
        r_pend_valid <= 1'b0;
      end
      if (w_drop) r_ovf <= 1'b1;
      if (r_state == S_RESP) r_data_hold <= w_result;
    end
  end

  // Data RAM: byte-enabled write and registered read, both on the access cycle.
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
    if (w_access) r_rd_word <= r_mem[w_idx];
  end

  assign dc_valid_o = (r_state == S_RESP);
  assign busy_o     = (r_state != S_IDLE);
  assign ovf_o      = r_ovf;
  assign dc_data_o  = dc_valid_o ? w_result : r_data_hold;

endmodule
